// File: rtl/spi_share_arbiter.sv
// rtl/spi_share_arbiter.sv - round-robin sharing of one SPI master between two requesters
// Optional hold-time watchdog: define SPI_ARB_TIMEOUT_EN to build the grant timeout and lockout.
module spi_share_arbiter #(
  parameter int                  CntWidth  = 16,
  parameter logic [CntWidth-1:0] HoldLimit = 16'd4096
) (
  input  logic       Clk_i,
  input  logic       Reset_i,
  input  logic [1:0] Req_i,
  output logic [1:0] Grant_o,
  input  logic [1:0] ReqWrite_i,
  input  logic [1:0] ReqReadNext_i,
  input  logic [7:0] ReqData0_i,
  input  logic [7:0] ReqData1_i,
  output logic [7:0] ReqDataOut_o,
  output logic [1:0] ReqFIFOEmpty_o,
  output logic [1:0] ReqFIFOFull_o,
  output logic [1:0] ReqTransmission_o,
  output logic       SPI_Write_o,
  output logic       SPI_ReadNext_o,
  output logic [7:0] SPI_Data_o,
  input  logic [7:0] SPI_Data_i,
  input  logic       SPI_FIFOEmpty_i,
  input  logic       SPI_FIFOFull_i,
  input  logic       SPI_Transmission_i,
  input  logic       TimeoutClr_i,
  output logic [1:0] TimeoutIRQ_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StOwn0  = 2'd1,
    StOwn1  = 2'd2,
    StDrain = 2'd3
  } stateT;

  stateT      state;
  stateT      nextState;
  logic       lastOwner;
  logic [1:0] eligible;
  logic       timeoutHit;
  logic       owning;

  assign owning = (state == StOwn0) || (state == StOwn1);

`ifdef SPI_ARB_TIMEOUT_EN
  logic [CntWidth-1:0] holdCnt;
  logic [1:0]          lockout;
  logic [1:0]          timeoutSet;
  logic [1:0]          timeoutIrq;

  // The owner is revoked on its HoldLimit-th granted cycle.
  assign timeoutHit   = owning && (holdCnt == HoldLimit - 1'b1);
  assign timeoutSet   = !timeoutHit ? 2'b00 : ((state == StOwn1) ? 2'b10 : 2'b01);
  assign eligible     = Req_i & ~lockout;
  assign TimeoutIRQ_o = timeoutIrq;

  // Hold counter: zero outside ownership, so it starts at zero on every new grant.
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      holdCnt <= '0;
    end else if (owning) begin
      holdCnt <= holdCnt + 1'b1;
    end else begin
      holdCnt <= '0;
    end
  end

  // Lockout lasts until the timed-out requester lets go; a new timeout beats a clear of the IRQ.
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      lockout    <= 2'b00;
      timeoutIrq <= 2'b00;
    end else begin
      lockout    <= timeoutSet | (lockout & Req_i);
      timeoutIrq <= (timeoutIrq & ~{2{TimeoutClr_i}}) | timeoutSet;
    end
  end
`else
  logic unusedCfg;

  assign timeoutHit   = 1'b0;
  assign eligible     = Req_i;
  assign TimeoutIRQ_o = 2'b00;
  assign unusedCfg    = TimeoutClr_i ^ HoldLimit[0] ^ (CntWidth != 0);
`endif

  // State register.
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state <= StIdle;
    end else begin
      state <= nextState;
    end
  end

  // Remember who released last so the other side wins the next tie.
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      lastOwner <= 1'b1;
    end else if (owning && (nextState == StDrain)) begin
      lastOwner <= (state == StOwn1);
    end
  end

  // Next-state: grant from IDLE, hold while requested, drain until the master goes idle.
  always_comb begin
    nextState = state;
    case (state)
      StIdle: begin
        case (eligible)
          2'b01:   nextState = StOwn0;
          2'b10:   nextState = StOwn1;
          2'b11:   nextState = lastOwner ? StOwn0 : StOwn1;
          default: nextState = StIdle;
        endcase
      end
      StOwn0: begin
        if (!Req_i[0] || timeoutHit) begin
          nextState = StDrain;
        end
      end
      StOwn1: begin
        if (!Req_i[1] || timeoutHit) begin
          nextState = StDrain;
        end
      end
      StDrain: begin
        if (!SPI_Transmission_i) begin
          nextState = StIdle;
        end
      end
      default: nextState = StIdle;
    endcase
  end

  // Outputs: registered grant from state, owner's strobes passed through, non-owner sees a busy master.
  always_comb begin
    Grant_o           = 2'b00;
    SPI_Write_o       = 1'b0;
    SPI_ReadNext_o    = 1'b0;
    SPI_Data_o        = 8'h00;
    ReqDataOut_o      = SPI_Data_i;
    ReqFIFOEmpty_o    = 2'b11;
    ReqFIFOFull_o     = 2'b11;
    ReqTransmission_o = 2'b11;
    case (state)
      StOwn0: begin
        Grant_o              = 2'b01;
        SPI_Write_o          = ReqWrite_i[0];
        SPI_ReadNext_o       = ReqReadNext_i[0];
        SPI_Data_o           = ReqData0_i;
        ReqFIFOEmpty_o[0]    = SPI_FIFOEmpty_i;
        ReqFIFOFull_o[0]     = SPI_FIFOFull_i;
        ReqTransmission_o[0] = SPI_Transmission_i;
      end
      StOwn1: begin
        Grant_o              = 2'b10;
        SPI_Write_o          = ReqWrite_i[1];
        SPI_ReadNext_o       = ReqReadNext_i[1];
        SPI_Data_o           = ReqData1_i;
        ReqFIFOEmpty_o[1]    = SPI_FIFOEmpty_i;
        ReqFIFOFull_o[1]     = SPI_FIFOFull_i;
        ReqTransmission_o[1] = SPI_Transmission_i;
      end
      default: begin
        Grant_o = 2'b00;
      end
    endcase
    if (Reset_i) begin
      SPI_Write_o    = 1'b0;
      SPI_ReadNext_o = 1'b0;
      SPI_Data_o     = 8'h00;
    end
  end

endmodule

// File: tb/tb_spi_share_arbiter.sv
// tb/tb_spi_share_arbiter.sv - randomized self-checking bench for spi_share_arbiter
module tb_spi_share_arbiter;

  localparam logic [15:0] HoldLimit = 16'd8;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] grant;
  logic [1:0] wr;
  logic [1:0] rn;
  logic [7:0] d0;
  logic [7:0] d1;
  logic [7:0] dataOut;
  logic [1:0] fifoEmptyOut;
  logic [1:0] fifoFullOut;
  logic [1:0] transOut;
  logic       spiWrite;
  logic       spiReadNext;
  logic [7:0] spiDataOut;
  logic [7:0] spiDataIn;
  logic       spiEmpty;
  logic       spiFull;
  logic       spiTrans;
  logic       clr;
  logic [1:0] irq;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycle       = 0;

  // Reference model: phase 0 = nobody owns, 1 = mOwner owns, 2 = waiting for the master to go idle
  int         mPhase = 0;
  int         mOwner = 0;
  int         mLast  = 1;
  int         mHeld  = 0;
  logic [1:0] mIrq   = 2'b00;
  logic [1:0] mLock  = 2'b00;

  always #5 clk = ~clk;

  spi_share_arbiter #(
    .CntWidth (16),
    .HoldLimit(HoldLimit)
  ) dut (
    .Clk_i             (clk),
    .Reset_i           (rst),
    .Req_i             (req),
    .Grant_o           (grant),
    .ReqWrite_i        (wr),
    .ReqReadNext_i     (rn),
    .ReqData0_i        (d0),
    .ReqData1_i        (d1),
    .ReqDataOut_o      (dataOut),
    .ReqFIFOEmpty_o    (fifoEmptyOut),
    .ReqFIFOFull_o     (fifoFullOut),
    .ReqTransmission_o (transOut),
    .SPI_Write_o       (spiWrite),
    .SPI_ReadNext_o    (spiReadNext),
    .SPI_Data_o        (spiDataOut),
    .SPI_Data_i        (spiDataIn),
    .SPI_FIFOEmpty_i   (spiEmpty),
    .SPI_FIFOFull_i    (spiFull),
    .SPI_Transmission_i(spiTrans),
    .TimeoutClr_i      (clr),
    .TimeoutIRQ_o      (irq)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Advance the model by one clock using the inputs that were stable at the edge.
  task automatic modelUpdate();
    logic [1:0] setMask;
    logic [1:0] elig;
    setMask = 2'b00;
    if (rst) begin
      mPhase = 0;
      mOwner = 0;
      mLast  = 1;
      mHeld  = 0;
      mIrq   = 2'b00;
      mLock  = 2'b00;
      return;
    end
    elig = req & ~mLock;
    case (mPhase)
      0: begin
        if (elig != 2'b00) begin
          if (elig == 2'b11) mOwner = 1 - mLast;
          else               mOwner = elig[0] ? 0 : 1;
          mPhase = 1;
          mHeld  = 0;
        end
      end
      1: begin
        mHeld++;
        if (TimeoutOn && (mHeld == int'(HoldLimit))) setMask[mOwner] = 1'b1;
        if (!req[mOwner] || (setMask != 2'b00)) begin
          mPhase = 2;
          mLast  = mOwner;
        end
      end
      default: begin
        if (!spiTrans) mPhase = 0;
      end
    endcase
    mIrq  = (clr ? 2'b00 : mIrq) | setMask;
    mLock = (mLock & req) | setMask;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    modelUpdate();
    cycle++;
  endtask

  // Compare every output against what the model and current inputs imply.
  task automatic checkAll();
    logic       own;
    logic [1:0] expGrant;
    logic [1:0] expEmpty;
    logic [1:0] expFull;
    logic [1:0] expTrans;
    logic       expWrite;
    logic       expRead;
    logic [7:0] expData;
    #1;
    own      = (mPhase == 1);
    expGrant = !own ? 2'b00 : ((mOwner == 1) ? 2'b10 : 2'b01);
    expEmpty = 2'b11;
    expFull  = 2'b11;
    expTrans = 2'b11;
    expWrite = 1'b0;
    expRead  = 1'b0;
    expData  = 8'h00;
    if (own) begin
      expEmpty[mOwner] = spiEmpty;
      expFull[mOwner]  = spiFull;
      expTrans[mOwner] = spiTrans;
      if (!rst) begin
        expWrite = wr[mOwner];
        expRead  = rn[mOwner];
        expData  = (mOwner == 1) ? d1 : d0;
      end
    end
    checkVal("grant", 32'(grant), 32'(expGrant));
    checkVal("spi_write", 32'(spiWrite), 32'(expWrite));
    checkVal("spi_readnext", 32'(spiReadNext), 32'(expRead));
    checkVal("spi_data", 32'(spiDataOut), 32'(expData));
    checkVal("rx_broadcast", 32'(dataOut), 32'(spiDataIn));
    checkVal("fifo_empty", 32'(fifoEmptyOut), 32'(expEmpty));
    checkVal("fifo_full", 32'(fifoFullOut), 32'(expFull));
    checkVal("transmission", 32'(transOut), 32'(expTrans));
    checkVal("timeout_irq", 32'(irq), 32'(mIrq));
  endtask

  initial begin
    int zeroCnt;
    rst       = 1'b1;
    req       = 2'b00;
    wr        = 2'b00;
    rn        = 2'b00;
    d0        = 8'h00;
    d1        = 8'h00;
    spiDataIn = 8'h5A;
    spiEmpty  = 1'b1;
    spiFull   = 1'b0;
    spiTrans  = 1'b0;
    clr       = 1'b0;

    // Reset state
    advance();
    advance();
    checkAll();
    checkVal("reset_grant", 32'(grant), 32'h0);
    checkVal("reset_irq", 32'(irq), 32'h0);

    // Single request: grant one cycle later, owner's write passes through in the same cycle
    rst = 1'b0;
    req = 2'b01;
    checkAll();
    advance();
    wr = 2'b01;
    d0 = 8'hA5;
    checkAll();
    checkVal("first_grant", 32'(grant), 32'h1);
    checkVal("owner_write", 32'(spiWrite), 32'h1);
    checkVal("owner_data", 32'(spiDataOut), 32'hA5);

    // Non-owner strobe ignored; non-owner sees full/busy
    advance();
    wr = 2'b10;
    d1 = 8'h77;
    checkAll();
    checkVal("nonowner_write", 32'(spiWrite), 32'h0);
    checkVal("nonowner_full", 32'(fifoFullOut[1]), 32'h1);
    checkVal("nonowner_trans", 32'(transOut[1]), 32'h1);
    checkVal("owner_full", 32'(fifoFullOut[0]), 32'h0);

    // Release while the master is busy for 20 cycles
    advance();
    wr       = 2'b00;
    req      = 2'b00;
    spiTrans = 1'b1;
    checkAll();
    advance();
    zeroCnt = 0;
    for (int i = 0; i < 20; i++) begin
      wr  = 2'b11;
      req = 2'b01;
      checkAll();
      if (grant == 2'b00) zeroCnt++;
      checkVal("drain_write", 32'(spiWrite), 32'h0);
      advance();
    end
    spiTrans = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkAll();
      if (grant != 2'b00) break;
      zeroCnt++;
      advance();
    end
    checkVal("drain_gap_ge21", 32'(zeroCnt >= 21), 32'h1);
    checkVal("regrant_after_drain", 32'(grant), 32'h1);

    // Round-robin tie
    rst = 1'b1;
    req = 2'b00;
    wr  = 2'b00;
    advance();
    rst = 1'b0;
    req = 2'b11;
    checkAll();
    advance();
    checkVal("tie_first", 32'(grant), 32'h1);
    req = 2'b10;
    checkAll();
    advance();
    req = 2'b11;
    checkAll();
    advance();
    checkAll();
    checkVal("idle_gap", 32'(grant), 32'h0);
    advance();
    checkAll();
    checkVal("rr_grant", 32'(grant), 32'h2);

    // Reset in the middle of an owned transaction
    wr = 2'b10;
    d1 = 8'h3C;
    checkAll();
    checkVal("own1_write", 32'(spiWrite), 32'h1);
    rst = 1'b1;
    checkAll();
    checkVal("reset_write_mask", 32'(spiWrite), 32'h0);
    checkVal("reset_data_mask", 32'(spiDataOut), 32'h0);
    advance();
    checkAll();
    checkVal("reset_revokes", 32'(grant), 32'h0);
    rst = 1'b0;
    req = 2'b00;
    wr  = 2'b00;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      advance();
      if ($urandom_range(0, 9) == 0) req[0] = ~req[0];
      if ($urandom_range(0, 9) == 0) req[1] = ~req[1];
      wr        = 2'($urandom);
      rn        = 2'($urandom);
      d0        = 8'($urandom);
      d1        = 8'($urandom);
      spiDataIn = 8'($urandom);
      spiEmpty  = 1'($urandom);
      spiFull   = 1'($urandom);
      spiTrans  = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      clr       = ($urandom_range(0, 15) == 0);
      checkAll();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
